mem_controller: RTL and testbench
=================================

// Module: mem_controller
// PURPOSE
//   Memory subsystem directly downstream of the cpu memory port. Accepts level
//   read/write strobes, serves word-addressed RAM or a small MMIO window, and
//   returns one single-cycle mem_done per request after WAIT_STATES extra
//   cycles. Requests never stall forever: unmapped accesses still complete.
// PARAMETERS
//   DEPTH_WORDS  4096           RAM size in 32-bit words (power of two)
//   WAIT_STATES  1              extra cycles between accept and done (0..15)
//   MMIO_BASE    32'h8000_0000  base of MMIO window (16-byte aligned)
//   INIT_FILE    ""             $readmemh image for RAM; empty = no preload
// PORTS
//   clk          in   1   clock, all logic on rising edge
//   rst_n        in   1   asynchronous active-low reset
//   mem_addr     in   32  byte address (bits [1:0] ignored; byte lanes via mask)
//   mem_wdata    in   32  lane-aligned write data
//   mem_wmask    in   4   byte-lane write enables
//   mem_wstrobe  in   1   write request, level, held until done
//   mem_rstrobe  in   1   read request, level, held until done
//   mem_rdata    out  32  read data, valid in the cycle mem_done=1
//   mem_done     out  1   one-cycle completion pulse
//   gpio_out     out  32  MMIO output register
//   bus_err      out  1   sticky: set by any unmapped access
// BEHAVIOUR
//   Reset (async, rst_n=0): state=IDLE, mem_done=0, mem_rdata=0, gpio_out=0,
//     bus_err=0, cycle counter=0. RAM contents are not reset. Reset mid-request
//     aborts it; a pending write that has not reached DONE is not committed.
//   FSM: IDLE -> (strobe) -> WAIT -> DONE -> IDLE.
//     IDLE: if mem_wstrobe|mem_rstrobe, latch addr/wdata/wmask/type, load wait
//       counter with WAIT_STATES; go WAIT (or DONE directly if WAIT_STATES=0).
//     WAIT: decrement counter; at 0 go DONE.
//     DONE: perform access, drive mem_done=1 for exactly this cycle, go IDLE.
//   Latency: strobe first high in IDLE cycle T -> mem_done high in cycle
//     T+1+WAIT_STATES. DONE->IDLE always costs one cycle, so a strobe still high
//     in the cycle after done is not re-accepted until that IDLE cycle; the
//     requester must drop the strobe the cycle after done.
//   Both strobes high in IDLE: treated as write (write wins).
//   Strobes changing during WAIT are ignored; latched request is served.
//   mem_rdata registered; updated only in DONE for reads; holds otherwise.
//   Writes: only lanes with wmask bit set change; mem_rdata unchanged on writes.
//   Decode (latched addr):
//     addr < DEPTH_WORDS*4: RAM, index addr[log2(DEPTH_WORDS)+1:2].
//     MMIO_BASE+0: gpio_out, RW, byte-masked.
//     MMIO_BASE+4: free-running 32-bit cycle counter, RO (writes ignored),
//       increments every clock, wraps 0xFFFF_FFFF -> 0; read returns value
//       sampled in the DONE cycle.
//     MMIO_BASE+8/+C and all other addresses: unmapped -> read returns 0,
//       write ignored, bus_err set (stays 1 until reset), mem_done still pulses.
//   RAM inferred as single-port synchronous block RAM with byte enables.
// TESTING
//   1 WAIT_STATES=1: rstrobe@0x0 with RAM[0]=0x0000_0013, hold -> done exactly 2
//     cycles after accept, rdata=0x0000_0013, done high one cycle only.
//   2 wstrobe addr 0x10 wdata 0xAABBCCDD mask 4'b0100, RAM[4]=0x11223344, then
//     read 0x10 -> 0x11BB3344.
//   3 Write 0xDEADBEEF to MMIO_BASE+0 mask 4'b1111 -> gpio_out=0xDEADBEEF after
//     DONE; write MMIO_BASE+4 -> counter unaffected, bus_err stays 0.
//   4 Read 0x4000_0000 (unmapped) -> rdata=0, done pulses, bus_err=1 and
//     remains 1 across later valid accesses until rst_n low.
//   5 Both strobes high with wdata 0x5 at 0x20 -> RAM[8]=0x5, rdata unchanged;
//     sweep WAIT_STATES=0 -> done at T+1.
//   6 Assert rst_n=0 during WAIT of a write to 0x24 -> done never pulses,
//     RAM[9] unchanged, all outputs 0 immediately (async).

Source files
------------

// File: rtl/mem_controller.sv
`default_nettype none
// ============================================================================
// Module   : mem_controller
// Purpose  : Word-addressed RAM plus a small MMIO window. Each read or write
//            strobe produces one mem_done pulse after a fixed number of wait
//            states. Unmapped accesses also complete and set a sticky bus_err.
// Revision : 1.0
// ============================================================================
module mem_controller #(
    parameter int          DEPTH_WORDS = 4096,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wmask,
    input  logic        mem_wstrobe,
    input  logic        mem_rstrobe,
    output logic [31:0] mem_rdata,
    output logic        mem_done,
    output logic [31:0] gpio_out,
    output logic        bus_err
);

    localparam int         ADDR_W      = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD   = 4'(WAIT_STATES);
    localparam logic [1:0] REGION_RAM  = 2'd0;
    localparam logic [1:0] REGION_GPIO = 2'd1;
    localparam logic [1:0] REGION_CTR  = 2'd2;
    localparam logic [1:0] REGION_NONE = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:2] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wmask_q, wmask_d;
    logic        is_wr_q, is_wr_d;
    logic [31:0] gpio_q, gpio_d;
    logic [31:0] ctr_q, ctr_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rsel_ram_q, rsel_ram_d;
    logic        err_q, err_d;

    logic              accept;
    logic              enter_done;
    logic [1:0]        region_cur;
    logic [1:0]        region_nxt;
    logic              ram_we;
    logic              ram_re;
    logic [ADDR_W-1:0] ram_idx;
    logic [31:0]       ram_rdata_q;
    logic [31:0]       ram [DEPTH_WORDS];
    logic              unused_addr_lsb;

    assign unused_addr_lsb = ^mem_addr[1:0];

    function automatic logic [1:0] decode(input logic [31:2] a);
        logic [1:0] r;
        r = REGION_NONE;
        if (a[31:ADDR_W+2] == '0) begin
            r = REGION_RAM;
        end else if (a[31:4] == MMIO_BASE[31:4]) begin
            if (a[3:2] == 2'd0) begin
                r = REGION_GPIO;
            end else if (a[3:2] == 2'd1) begin
                r = REGION_CTR;
            end
        end
        return r;
    endfunction

    // Request capture; write wins when both strobes are high.
    always_comb begin
        accept  = (state_q == S_IDLE) && (mem_wstrobe || mem_rstrobe);
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wmask_d = wmask_q;
        is_wr_d = is_wr_q;
        if (accept) begin
            addr_d  = mem_addr[31:2];
            wdata_d = mem_wdata;
            wmask_d = mem_wmask;
            is_wr_d = mem_wstrobe;
        end
    end

    assign region_cur = decode(addr_q);
    assign region_nxt = decode(addr_d);
    assign ram_idx    = addr_d[ADDR_W+1:2];

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    cnt_d = WAIT_LOAD;
                    if (WAIT_LOAD == 4'd0) begin
                        state_d    = S_DONE;
                        enter_done = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d    = S_DONE;
                    enter_done = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Read data is fetched on the edge into DONE so it is valid with mem_done;
    // the counter value loaded is the one the counter holds during DONE.
    always_comb begin
        gpio_d     = gpio_q;
        err_d      = err_q;
        rdata_d    = rdata_q;
        rsel_ram_d = rsel_ram_q;
        ctr_d      = ctr_q + 32'd1;
        ram_we     = 1'b0;
        ram_re     = 1'b0;
        if (enter_done && !is_wr_d) begin
            rsel_ram_d = 1'b0;
            case (region_nxt)
                REGION_RAM: begin
                    ram_re     = 1'b1;
                    rsel_ram_d = 1'b1;
                end
                REGION_GPIO: rdata_d = gpio_q;
                REGION_CTR:  rdata_d = ctr_d;
                default:     rdata_d = 32'd0;
            endcase
        end
        if (state_q == S_DONE) begin
            if (region_cur == REGION_NONE) begin
                err_d = 1'b1;
            end else if (is_wr_q) begin
                if (region_cur == REGION_RAM) begin
                    ram_we = 1'b1;
                end else if (region_cur == REGION_GPIO) begin
                    for (int b = 0; b < 4; b++) begin
                        if (wmask_q[b]) begin
                            gpio_d[8*b +: 8] = wdata_q[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 4'd0;
            addr_q     <= '0;
            wdata_q    <= 32'd0;
            wmask_q    <= 4'd0;
            is_wr_q    <= 1'b0;
            gpio_q     <= 32'd0;
            ctr_q      <= 32'd0;
            rdata_q    <= 32'd0;
            rsel_ram_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            is_wr_q    <= is_wr_d;
            gpio_q     <= gpio_d;
            ctr_q      <= ctr_d;
            rdata_q    <= rdata_d;
            rsel_ram_q <= rsel_ram_d;
            err_q      <= err_d;
        end
    end

    // Single-port synchronous RAM with byte enables; contents survive reset.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            for (int b = 0; b < 4; b++) begin
                if (wmask_q[b]) begin
                    ram[ram_idx][8*b +: 8] <= wdata_q[8*b +: 8];
                end
            end
        end
        if (ram_re) begin
            ram_rdata_q <= ram[ram_idx];
        end
    end

    assign mem_rdata = rsel_ram_q ? ram_rdata_q : rdata_q;
    assign mem_done  = (state_q == S_DONE);
    assign gpio_out  = gpio_q;
    assign bus_err   = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_controller
// Purpose  : Directed and randomized checks of mem_controller against a
//            behavioural model of RAM, GPIO, cycle counter and bus error.
// Revision : 1.0
// ============================================================================
module tb_mem_controller;

    localparam logic [31:0] MMIO = 32'h8000_0000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [31:0] a1, wd1, rd1, gpio1;
    logic [3:0]  wm1;
    logic        ws1, rs1, done1, err1;
    logic [31:0] a0, wd0, rd0, gpio0;
    logic [3:0]  wm0;
    logic        ws0, rs0, done0, err0;

    mem_controller #(.WAIT_STATES(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .mem_addr(a1), .mem_wdata(wd1), .mem_wmask(wm1),
        .mem_wstrobe(ws1), .mem_rstrobe(rs1), .mem_rdata(rd1), .mem_done(done1),
        .gpio_out(gpio1), .bus_err(err1)
    );

    mem_controller #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .mem_addr(a0), .mem_wdata(wd0), .mem_wmask(wm0),
        .mem_wstrobe(ws0), .mem_rstrobe(rs0), .mem_rdata(rd0), .mem_done(done0),
        .gpio_out(gpio0), .bus_err(err0)
    );

    // Reference cycle count: zero in reset, +1 every clock.
    logic [31:0] tb_cyc;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) tb_cyc <= 32'd0;
        else        tb_cyc <= tb_cyc + 32'd1;
    end

    int checks   = 0;
    int failures = 0;

    logic [31:0] m_ram [0:4095];
    logic [31:0] m_gpio  = 32'd0;
    logic [31:0] m_rdata = 32'd0;
    logic        m_err   = 1'b0;
    logic [31:0] last_got;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic int region(input logic [31:0] a);
        if (a < 32'd16384)                 return 0;
        if ((a >> 2) == (MMIO >> 2))       return 1;
        if ((a >> 2) == ((MMIO + 4) >> 2)) return 2;
        return 3;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    task automatic access1(input logic wr, input logic rd, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [3:0] mask,
                           output logic [31:0] rdata, output int lat, output logic [31:0] cyc);
        @(posedge clk); #1;
        a1 = addr; wd1 = wdata; wm1 = mask; ws1 = wr; rs1 = rd;
        lat = 0;
        do begin
            @(posedge clk); #1;
            lat++;
        end while (!done1 && lat < 20);
        rdata = rd1;
        cyc   = tb_cyc;
        ws1 = 1'b0; rs1 = 1'b0;
    endtask

    task automatic txn(input string tag, input logic wr, input logic rd, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] mask);
        logic [31:0] got, cyc, exp;
        int lat, rg, idx;
        access1(wr, rd, addr, wdata, mask, got, lat, cyc);
        chk({tag, "_latency"}, 32'(lat), 32'd2);
        rg  = region(addr);
        idx = int'(addr >> 2) % 4096;
        if (wr) begin
            exp = m_rdata;
            case (rg)
                0:       m_ram[idx] = merge(m_ram[idx], wdata, mask);
                1:       m_gpio = merge(m_gpio, wdata, mask);
                3:       m_err = 1'b1;
                default: ;
            endcase
        end else begin
            case (rg)
                0:       exp = m_ram[idx];
                1:       exp = m_gpio;
                2:       exp = cyc;
                default: begin exp = 32'd0; m_err = 1'b1; end
            endcase
            m_rdata = exp;
        end
        chk({tag, "_rdata"}, got, exp);
        last_got = got;
        @(posedge clk); #1;
        chk({tag, "_done_one_cycle"}, {31'd0, done1}, 32'd0);
        chk({tag, "_bus_err"}, {31'd0, err1}, {31'd0, m_err});
        chk({tag, "_gpio"}, gpio1, m_gpio);
    endtask

    initial begin
        logic [31:0] got, exp;
        int lat, sel, w;
        logic [31:0] bad_addrs [5];
        bad_addrs[0] = MMIO + 32'h8;
        bad_addrs[1] = MMIO + 32'hC;
        bad_addrs[2] = 32'h4000_0000;
        bad_addrs[3] = 32'h0000_4000;
        bad_addrs[4] = MMIO + 32'h10;

        rst_n = 1'b0;
        a1 = 0; wd1 = 0; wm1 = 0; ws1 = 0; rs1 = 0;
        a0 = 0; wd0 = 0; wm0 = 0; ws0 = 0; rs0 = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_done",  {31'd0, done1}, 32'd0);
        chk("reset_rdata", rd1, 32'd0);
        chk("reset_gpio",  gpio1, 32'd0);
        chk("reset_err",   {31'd0, err1}, 32'd0);
        rst_n = 1'b1;

        // Fill the RAM words used by the bench.
        for (int i = 0; i < 32; i++) begin
            w = int'($urandom);
            if (i == 0) w = 32'h0000_0013;
            if (i == 4) w = 32'h1122_3344;
            m_ram[i] = 32'(w);
            txn("fill", 1'b1, 1'b0, 32'(i * 4), 32'(w), 4'hF);
        end

        txn("t1_read0", 1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
        chk("t1_literal", last_got, 32'h0000_0013);

        txn("t2_write", 1'b1, 1'b0, 32'h10, 32'hAABB_CCDD, 4'b0100);
        txn("t2_read", 1'b0, 1'b1, 32'h10, 32'h0, 4'h0);
        chk("t2_literal", last_got, 32'h11BB_3344);

        txn("t3_gpio_wr", 1'b1, 1'b0, MMIO, 32'hDEAD_BEEF, 4'hF);
        chk("t3_gpio_literal", gpio1, 32'hDEAD_BEEF);
        txn("t3_ctr_wr", 1'b1, 1'b0, MMIO + 32'h4, 32'h0, 4'hF);
        txn("t3_ctr_rd", 1'b0, 1'b1, MMIO + 32'h4, 32'h0, 4'h0);
        chk("t3_err_clear", {31'd0, err1}, 32'd0);

        txn("t4_unmapped", 1'b0, 1'b1, 32'h4000_0000, 32'h0, 4'h0);
        chk("t4_err_set", {31'd0, err1}, 32'd1);
        txn("t4_valid_after", 1'b0, 1'b1, 32'h4, 32'h0, 4'h0);
        chk("t4_err_sticky", {31'd0, err1}, 32'd1);

        txn("t5_both", 1'b1, 1'b1, 32'h20, 32'h5, 4'hF);
        txn("t5_readback", 1'b0, 1'b1, 32'h20, 32'h0, 4'h0);
        chk("t5_literal", last_got, 32'h5);

        for (int n = 0; n < 60; n++) begin
            sel = int'($urandom_range(0, 9));
            w   = int'($urandom_range(0, 31));
            if (sel <= 5)
                txn("rnd_ram", 1'($urandom_range(0, 1)), 1'b1, 32'(w * 4) + 32'($urandom_range(0, 3)),
                    $urandom, 4'($urandom_range(0, 15)));
            else if (sel == 6)
                txn("rnd_gpio", 1'($urandom_range(0, 1)), 1'b1, MMIO + 32'($urandom_range(0, 3)),
                    $urandom, 4'($urandom_range(0, 15)));
            else if (sel == 7)
                txn("rnd_ctr", 1'($urandom_range(0, 1)), 1'b1, MMIO + 32'h4, $urandom, 4'hF);
            else if (sel == 8)
                txn("rnd_unmapped", 1'($urandom_range(0, 1)), 1'b1, bad_addrs[$urandom_range(0, 4)],
                    $urandom, 4'hF);
            else
                txn("rnd_both", 1'b1, 1'b1, 32'(w * 4), $urandom, 4'($urandom_range(0, 15)));
        end

        // Zero wait states: done one cycle after acceptance.
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            a0 = 32'h20; wd0 = 32'h0BAD_F00D; wm0 = 4'hF; ws0 = (k == 0); rs0 = (k == 1);
            lat = 0;
            do begin
                @(posedge clk); #1;
                lat++;
            end while (!done0 && lat < 20);
            got = rd0;
            ws0 = 1'b0; rs0 = 1'b0;
            chk("ws0_latency", 32'(lat), 32'd1);
            if (k == 1) chk("ws0_rdata", got, 32'h0BAD_F00D);
            @(posedge clk); #1;
            chk("ws0_done_one_cycle", {31'd0, done0}, 32'd0);
        end

        // Reset in the middle of a write must abort it.
        txn("t6_prep", 1'b0, 1'b1, 32'h0, 32'h0, 4'h0);
        exp = m_ram[9];
        @(posedge clk); #1;
        a1 = 32'h24; wd1 = ~exp; wm1 = 4'hF; ws1 = 1'b1; rs1 = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk("t6_async_done",  {31'd0, done1}, 32'd0);
        chk("t6_async_rdata", rd1, 32'd0);
        chk("t6_async_gpio",  gpio1, 32'd0);
        chk("t6_async_err",   {31'd0, err1}, 32'd0);
        ws1 = 1'b0;
        m_gpio = 32'd0; m_err = 1'b0; m_rdata = 32'd0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk); #1;
            if (c == 2) rst_n = 1'b1;
            chk("t6_no_done", {31'd0, done1}, 32'd0);
        end
        txn("t6_ram9", 1'b0, 1'b1, 32'h24, 32'h0, 4'h0);
        chk("t6_ram9_literal", last_got, exp);
        txn("t6_ctr_after_reset", 1'b0, 1'b1, MMIO + 32'h4, 32'h0, 4'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
